// File: rtl/hcm_row_reader_pkg.sv
// hcm_row_reader_pkg: shared HCM geometry, sweep states and row helpers.
package hcm_row_reader_pkg;
  localparam int NCOLS_HCM = 32;
  localparam int NROWS_HCM = 65536;
  localparam int ROWINDEXBITS_HCM = $clog2(NROWS_HCM);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;
  typedef logic [ROWINDEXBITS_HCM-1:0] row_t;
  typedef struct packed {
    row_t                 row;
    logic [NCOLS_HCM-1:0] data;
  } entry_t;
  function automatic row_t next_row(row_t r);
    return (32'(r) == NROWS_HCM - 1) ? '0 : row_t'(r + 1'b1);
  endfunction
endpackage

// File: rtl/hcm_row_reader_if.sv
// hcm_row_reader_if: HCM read port plus the downstream valid/ready row stream.
interface hcm_row_reader_if;
  import hcm_row_reader_pkg::*;
  logic                 readRow;
  row_t                 rowToRead;
  logic [NCOLS_HCM-1:0] rowReadOutput;
  row_t                 rowPassed;
  logic                 outValid;
  logic                 outReady;
  row_t                 outRow;
  logic [NCOLS_HCM-1:0] outData;
  modport master (output readRow, rowToRead, outValid, outRow, outData,
                  input rowReadOutput, rowPassed, outReady);
  modport slave (input readRow, rowToRead, outValid, outRow, outData,
                 output rowReadOutput, rowPassed, outReady);
endinterface

// File: rtl/hcm_row_fifo.sv
// hcm_row_fifo: synchronous FIFO with registered storage, count and full/empty flags.
module hcm_row_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d  = wr_q + AW'(push);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/hcm_row_reader.sv
// hcm_row_reader: sweeps an inclusive (wrapping) HCM row range, one read per cycle,
// and streams returned rows downstream through a credit-guarded FIFO.
module hcm_row_reader
  import hcm_row_reader_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  row_t             firstRow,
  input  row_t             lastRow,
  input  logic             skipEmpty,
  input  logic             hcmBusy,
  output logic             busy,
  output logic             done,
  output logic             rowMismatch,
  hcm_row_reader_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  state_t state_q, state_d;
  row_t next_q, next_d, last_q, last_d, row_q, row_d, cur, cur_last;
  logic skip_q, skip_d, rd_q, rd_d, done_q, done_d, mism_q, mism_d;
  logic [CW-1:0] infl_q, infl_d, count, cnt_n;
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  row_t pi_q [READ_LATENCY];
  row_t pi_d [READ_LATENCY];
  logic accept, credit, issue, ret, keep, push, pop, full, empty;
  entry_t head;
  always_comb begin
    accept   = state_q == IDLE && start;
    cur      = accept ? firstRow : next_q;
    cur_last = accept ? lastRow : last_q;
    pop      = !empty && bus.outReady;
    ret      = pv_q[READ_LATENCY-1];
    keep     = ret && !(skip_q && bus.rowReadOutput == '0);
    push     = keep && (!full || pop);
    // a slot being popped this cycle is already free for a new read
    credit   = SW'(infl_q) + SW'(count) < SW'(FIFO_DEPTH) + SW'(pop);
    issue    = (accept || state_q == ISSUE) && !hcmBusy && credit;
    rd_d     = issue;
    row_d    = issue ? cur : row_q;
    next_d   = issue ? next_row(cur) : cur;
    last_d   = cur_last;
    skip_d   = accept ? skipEmpty : skip_q;
    infl_d   = infl_q + CW'(issue) - CW'(ret);
    cnt_n    = count + CW'(push) - CW'(pop);
    pv_d     = pv_q;
    pi_d     = pi_q;
    pv_d[0]  = rd_q;
    pi_d[0]  = row_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
    mism_d   = accept ? 1'b0 : mism_q | (ret && bus.rowPassed != pi_q[READ_LATENCY-1]);
    done_d   = state_q == DRAIN && infl_d == '0 && cnt_n == '0;
    state_d  = state_q;
    if (accept) state_d = ISSUE;
    if (issue && cur == cur_last) state_d = DRAIN;
    if (done_d) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      next_q  <= '0;
      last_q  <= '0;
      row_q   <= '0;
      skip_q  <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      mism_q  <= 1'b0;
      infl_q  <= '0;
      pv_q    <= '0;
      pi_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      last_q  <= last_d;
      row_q   <= row_d;
      skip_q  <= skip_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      mism_q  <= mism_d;
      infl_q  <= infl_d;
      pv_q    <= pv_d;
      pi_q    <= pi_d;
    end
  hcm_row_fifo #(.W(ROWINDEXBITS_HCM + NCOLS_HCM), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .resetN(resetN),
    .push  (push),
    .din   ({pi_q[READ_LATENCY-1], bus.rowReadOutput}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  assign bus.readRow   = rd_q;
  assign bus.rowToRead = row_q;
  assign bus.outValid  = !empty;
  assign bus.outRow    = head.row;
  assign bus.outData   = head.data;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign rowMismatch   = mism_q;
endmodule

// File: tb/tb_hcm_row_reader.sv
// tb_hcm_row_reader: randomized sweeps against an HCM responder and a queue-based
// reference of which rows must come out, in which order.
module tb_hcm_row_reader;
  localparam int RL = 2;
  localparam int DEPTH = 4;
  logic clk, resetN, start, skipEmpty, hcmBusy, busy, done, rowMismatch;
  logic [15:0] firstRow, lastRow;
  hcm_row_reader_if bus ();
  hcm_row_reader #(.READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .firstRow   (firstRow),
    .lastRow    (lastRow),
    .skipEmpty  (skipEmpty),
    .hcmBusy    (hcmBusy),
    .busy       (busy),
    .done       (done),
    .rowMismatch(rowMismatch),
    .bus        (bus)
  );
  logic [31:0] hmem [65536];
  logic [47:0] expq [$];
  logic [47:0] prev_entry;
  int n_chk, n_fail, cyc, cyc0, ndone, first_v, done_rel, nreads, npop, maxocc, bad_rd, n_extra;
  int rdy_mode, bsy_mode, bad_row;
  bit stall_prev;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.outReady = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 2) == 0) : 1'b0;
      hcmBusy = bsy_mode != 0 && $urandom_range(0, 3) == 0;
    end
  end
  // HCM model: a read seen in cycle t answers with data and row index in cycle t+RL
  initial begin
    logic hv [RL];
    logic [15:0] hr [RL];
    logic v0;
    logic [15:0] r0;
    for (int i = 0; i < RL; i++) begin hv[i] = 0; hr[i] = 0; end
    forever begin
      @(negedge clk);
      v0 = bus.readRow;
      r0 = bus.rowToRead;
      @(posedge clk);
      #1;
      for (int i = RL - 1; i > 0; i--) begin hv[i] = hv[i-1]; hr[i] = hr[i-1]; end
      hv[0] = v0;
      hr[0] = r0;
      if (hv[RL-1]) begin
        bus.rowReadOutput = hmem[hr[RL-1]];
        bus.rowPassed = int'(hr[RL-1]) == bad_row ? hr[RL-1] + 16'd1 : hr[RL-1];
      end else begin
        bus.rowReadOutput = $urandom;
        bus.rowPassed = 16'($urandom);
      end
    end
  end
  always @(negedge clk) begin
    if (resetN) begin
      if (bus.readRow) begin
        nreads++;
        if (!busy) bad_rd++;
      end
      if (stall_prev) begin
        chk("hold_valid", 64'(bus.outValid), 64'd1);
        chk("hold_entry", 64'({bus.outRow, bus.outData}), 64'(prev_entry));
      end
      if (bus.outValid && first_v < 0) first_v = cyc - cyc0;
      if (bus.outValid && bus.outReady) begin
        npop++;
        if (expq.size() == 0) n_extra++;
        else chk("out_entry", 64'({bus.outRow, bus.outData}), 64'(expq.pop_front()));
      end
      if (nreads - npop > maxocc) maxocc = nreads - npop;
      stall_prev = bus.outValid && !bus.outReady;
      prev_entry = {bus.outRow, bus.outData};
      if (done) begin
        ndone++;
        done_rel = cyc - cyc0;
      end
    end else stall_prev = 0;
  end
  task automatic sweep(input logic [15:0] f, input logic [15:0] l, input logic sk,
                       input int rmode, input int bmode, input int bad, input bit poke);
    logic [15:0] r;
    bit last;
    expq.delete();
    r = f;
    do begin
      if (!(sk && hmem[r] == 0)) expq.push_back({r, hmem[r]});
      last = r == l;
      r = r + 16'd1;
    end while (!last);
    rdy_mode = rmode; bsy_mode = bmode; bad_row = bad;
    ndone = 0; first_v = -1; done_rel = -1; nreads = 0; npop = 0; maxocc = 0; bad_rd = 0; n_extra = 0;
    @(posedge clk);
    #1;
    firstRow = f; lastRow = l; skipEmpty = sk; start = 1; cyc0 = cyc;
    @(posedge clk);
    #1;
    start = 0; skipEmpty = ~sk; firstRow = 16'($urandom); lastRow = 16'($urandom);
    chk("busy_on_start", 64'(busy), 64'd1);
    chk("mismatch_cleared", 64'(rowMismatch), 64'd0);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      firstRow = 100; lastRow = 100; start = 1;
      @(posedge clk);
      #1;
      start = 0;
    end
    for (int i = 0; i < 3000 && ndone == 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("done_seen", 64'(ndone), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 64'(ndone), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("left_over", 64'(expq.size()), 64'd0);
    chk("extra_out", 64'(n_extra), 64'd0);
    chk("read_outside_sweep", 64'(bad_rd), 64'd0);
    chk("mismatch_flag", 64'(rowMismatch), 64'(bad >= 0));
    if (!sk) chk("occupancy_bound", 64'(maxocc <= DEPTH), 64'd1);
  endtask
  initial begin
    int seen;
    logic [15:0] f;
    n_chk = 0; n_fail = 0; cyc = 0; bad_row = -1; rdy_mode = 0; bsy_mode = 0;
    start = 0; firstRow = 0; lastRow = 0; skipEmpty = 0; hcmBusy = 0;
    bus.outReady = 1; bus.rowReadOutput = 0; bus.rowPassed = 0;
    for (int i = 0; i < 65536; i++) hmem[i] = i + 1;
    resetN = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({bus.readRow, bus.outValid, busy, done, rowMismatch}), 64'd0);
    chk("reset_data", 64'({bus.rowToRead, bus.outRow, bus.outData}), 64'd0);
    resetN = 1;
    sweep(0, 9, 0, 0, 0, -1, 0);
    chk("first_valid_cycle", 64'(first_v), 64'd4);
    chk("done_cycle", 64'(done_rel), 64'd14);
    sweep(65534, 1, 0, 0, 0, -1, 0);
    sweep(5, 5, 0, 0, 0, -1, 0);
    for (int i = 0; i < 10; i++) hmem[i] = 0;
    hmem[3] = 32'h0000_00a5;
    hmem[7] = 32'h7700_0000;
    sweep(0, 9, 1, 0, 0, -1, 0);
    chk("skip_pops", 64'(npop), 64'd2);
    for (int i = 0; i < 65536; i++) hmem[i] = i + 1;
    sweep(0, 9, 0, 0, 0, 5, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("mismatch_sticky", 64'(rowMismatch), 64'd1);
    sweep(0, 49, 0, 1, 1, -1, 1);
    chk("backpressure_pops", 64'(npop), 64'd50);
    for (int t = 0; t < 4; t++) begin
      f = t[0] ? 16'(65530 + $urandom_range(0, 5)) : 16'($urandom);
      for (int i = 0; i <= 40; i++) hmem[16'(f + 16'(i))] = $urandom_range(0, 1) ? $urandom : 32'd0;
      sweep(f, 16'(f + 16'($urandom_range(0, 40))), 1'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), -1, 0);
    end
    for (int i = 0; i < 65536; i++) hmem[i] = i + 1;
    expq.delete();
    rdy_mode = 2; bsy_mode = 0; bad_row = -1;
    @(posedge clk);
    #1;
    firstRow = 0; lastRow = 49; skipEmpty = 0; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_valid", 64'(bus.outValid), 64'd1);
    resetN = 0;
    #1;
    chk("midreset_ctrl", 64'({bus.readRow, bus.outValid, busy, done, rowMismatch}), 64'd0);
    chk("midreset_addr", 64'(bus.rowToRead), 64'd0);
    chk("midreset_data", 64'({bus.outRow, bus.outData}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1;
    rdy_mode = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.outValid || busy || bus.readRow) seen++;
    end
    chk("quiet_after_reset", 64'(seen), 64'd0);
    sweep(10, 20, 0, 1, 1, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
    $fatal(1);
  end
endmodule
